// File: rtl/sram_bram_responder.sv
// sram_bram_responder: block-RAM stand-in for the external SRAM controller.
// Responds on the sram_req/sram_ready interface, serving full-word reads and
// byte-masked writes from an internal 2^ADDR_W x 16 array. Access pacing
// (BUSY_CYC) and read latency (RD_LAT) mimic the real controller so the
// requester's flow control sees the same behaviour.
//
// Optional feature macro: SRAM_RESP_OOR_CHECK_EN
//   defined   : addresses >= 2^ADDR_W are out of range; writes are dropped,
//               reads return 16'hDEAD, and oor_err is set until reset.
//   undefined : upper address bits are ignored (aliasing), oor_err is 0.
//
// Handshake: an access is accepted on a rising edge where sram_req and
// sram_ready are both high; sram_rd, sram_addr, sram_be and sram_wr_data are
// sampled on that edge only. Each read yields exactly one sram_rd_data_vld
// pulse RD_LAT edges after acceptance, in acceptance order.

module sram_bram_responder #(
   parameter int ADDR_W   = 10,
   parameter int RD_LAT   = 2,
   parameter int BUSY_CYC = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sram_req,
   output logic        sram_ready,
   input  logic        sram_rd,
   input  logic [17:0] sram_addr,
   input  logic [1:0]  sram_be,
   input  logic [15:0] sram_wr_data,
   output logic        sram_rd_data_vld,
   output logic [15:0] sram_rd_data,
   output logic        oor_err
);

   localparam int          DEPTH     = 1 << ADDR_W;
   localparam logic [15:0] OOR_DATA  = 16'hDEAD;
   // Counter preload; BUSY_CYC=0 never enters BUSY, so the value is unused then.
   localparam logic [2:0]  BUSY_LOAD = (BUSY_CYC > 0) ? 3'(BUSY_CYC - 1) : 3'd0;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t              state;
   logic                ready_q;
   logic [2:0]          busy_cnt;

   logic                accept;
   logic                wr_en;
   logic                rd_en;
   logic                addr_oor;
   logic [ADDR_W-1:0]   word_idx;

   logic [15:0]         mem [DEPTH];
   logic [RD_LAT-1:0]   vld_pipe;
   logic [15:0]         data_pipe [RD_LAT];

   assign accept   = sram_req && ready_q;
   assign word_idx = sram_addr[ADDR_W-1:0];

`ifdef SRAM_RESP_OOR_CHECK_EN
   assign addr_oor = |sram_addr[17:ADDR_W];
`else
   // Upper address bits are deliberately ignored so addresses alias.
   logic addr_hi_unused;
   assign addr_hi_unused = |sram_addr[17:ADDR_W];
   assign addr_oor       = 1'b0;
`endif

   // Out-of-range writes never touch the array; reads are always launched.
   assign wr_en = accept && !sram_rd && !addr_oor;
   assign rd_en = accept && sram_rd;

   assign sram_ready = ready_q;

   // Pacing FSM: RESET -> IDLE, then IDLE <-> BUSY around each accepted access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_RESET;
         ready_q  <= 1'b0;
         busy_cnt <= 3'd0;
      end else begin
         case (state)
            ST_RESET: begin
               state   <= ST_IDLE;
               ready_q <= 1'b1;
            end
            ST_IDLE: begin
               if (accept && (BUSY_CYC > 0)) begin
                  state    <= ST_BUSY;
                  ready_q  <= 1'b0;
                  busy_cnt <= BUSY_LOAD;
               end
            end
            ST_BUSY: begin
               if (busy_cnt == 3'd0) begin
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  busy_cnt <= busy_cnt - 3'd1;
               end
            end
            default: begin
               state    <= ST_RESET;
               ready_q  <= 1'b0;
               busy_cnt <= 3'd0;
            end
         endcase
      end
   end

   // Array write with per-byte lane enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (sram_be[0]) mem[word_idx][7:0]  <= sram_wr_data[7:0];
         if (sram_be[1]) mem[word_idx][15:8] <= sram_wr_data[15:8];
      end
   end

   // Read data path: stage 0 is the array read register, later stages delay it.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         data_pipe[0] <= addr_oor ? OOR_DATA : mem[word_idx];
      end
      for (int i = 1; i < RD_LAT; i++) begin
         data_pipe[i] <= data_pipe[i-1];
      end
   end

   // Read valid pipeline; reset discards every read still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // Data is forced to zero outside the valid pulse, which also gives the reset value.
   assign sram_rd_data_vld = vld_pipe[RD_LAT-1];
   assign sram_rd_data     = vld_pipe[RD_LAT-1] ? data_pipe[RD_LAT-1] : 16'h0000;

`ifdef SRAM_RESP_OOR_CHECK_EN
   logic oor_q;

   // Sticky out-of-range flag, set on the acceptance edge of an offending access.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oor_q <= 1'b0;
      end else if (accept && addr_oor) begin
         oor_q <= 1'b1;
      end
   end

   assign oor_err = oor_q;
`else
   assign oor_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_bram_responder.sv
// Bench for sram_bram_responder. Three instances with different pacing and
// latency share the data/address/reset inputs and have private sram_req lines.
// A timeline model (ready-from cycle, queue of due read results, array image)
// predicts every output in every cycle; a directed table and a few hand-written
// sequences check the documented corner cases against constant values.

module tb_sram_bram_responder;

  localparam int          NI        = 3;
  localparam logic [15:0] DEAD_WORD = 16'hDEAD;
`ifdef SRAM_RESP_OOR_CHECK_EN
  localparam bit          OOR_EN    = 1'b1;
`else
  localparam bit          OOR_EN    = 1'b0;
`endif

  // Instance 0: defaults. Instance 1: back-to-back. Instance 2: long latency.
  function automatic int lat_of(input int i);
    case (i)
      0: return 2;
      1: return 3;
      default: return 4;
    endcase
  endfunction

  function automatic int busy_of(input int i);
    case (i)
      0: return 1;
      1: return 0;
      default: return 2;
    endcase
  endfunction

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic [17:0] addr = '0;
  logic [1:0]  be = '0;
  logic [15:0] wdata = '0;
  logic [2:0]  req_v = '0;
  logic [2:0]  rdy_v;
  logic [2:0]  vld_v;
  logic [2:0]  oor_v;
  logic [2:0][15:0] rdat_v;

  always #5 clk = ~clk;

  sram_bram_responder #(.ADDR_W(10), .RD_LAT(2), .BUSY_CYC(1)) u_a (
    .clk(clk), .reset(rst), .sram_req(req_v[0]), .sram_ready(rdy_v[0]),
    .sram_rd(rd), .sram_addr(addr), .sram_be(be), .sram_wr_data(wdata),
    .sram_rd_data_vld(vld_v[0]), .sram_rd_data(rdat_v[0]), .oor_err(oor_v[0]));

  sram_bram_responder #(.ADDR_W(10), .RD_LAT(3), .BUSY_CYC(0)) u_b (
    .clk(clk), .reset(rst), .sram_req(req_v[1]), .sram_ready(rdy_v[1]),
    .sram_rd(rd), .sram_addr(addr), .sram_be(be), .sram_wr_data(wdata),
    .sram_rd_data_vld(vld_v[1]), .sram_rd_data(rdat_v[1]), .oor_err(oor_v[1]));

  sram_bram_responder #(.ADDR_W(10), .RD_LAT(4), .BUSY_CYC(2)) u_c (
    .clk(clk), .reset(rst), .sram_req(req_v[2]), .sram_ready(rdy_v[2]),
    .sram_rd(rd), .sram_addr(addr), .sram_be(be), .sram_wr_data(wdata),
    .sram_rd_data_vld(vld_v[2]), .sram_rd_data(rdat_v[2]), .oor_err(oor_v[2]));

  // ---------------- reference model ----------------
  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
  } rd_t;

  int          k = 0;                // interval index: time after edge k
  bit          in_rst = 1'b1;
  int          ready_from [NI];
  bit          oor_m [NI];
  logic [15:0] mem_m [NI][1024];
  rd_t         rd_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", name, inst, k, act, exp);
    end
  endtask

  task automatic model_accept(input int i);
    logic [9:0]  idx;
    bit          oor;
    logic [15:0] val;
    idx = addr[9:0];
    oor = OOR_EN && (addr[17:10] != 8'd0);
    if (rd) begin
      val = oor ? DEAD_WORD : mem_m[i][idx];
      rd_q.push_back('{inst: i, due: k + lat_of(i), data: val});
    end else if (!oor) begin
      if (be[0]) mem_m[i][idx][7:0]  = wdata[7:0];
      if (be[1]) mem_m[i][idx][15:8] = wdata[15:8];
    end
    if (oor) oor_m[i] = 1'b1;
    ready_from[i] = k + 1 + busy_of(i);
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      int found;
      bit exp_rdy;
      exp_rdy = !in_rst && (k >= ready_from[i]);
      chk("ready", i, rdy_v[i], exp_rdy);
      found = -1;
      foreach (rd_q[j]) if (rd_q[j].inst == i && rd_q[j].due == k) found = j;
      if (found >= 0) begin
        chk("rd_vld", i, vld_v[i], 1);
        chk("rd_data", i, rdat_v[i], rd_q[found].data);
        rd_q.delete(found);
      end else begin
        chk("rd_vld", i, vld_v[i], 0);
      end
      chk("oor_err", i, oor_v[i], oor_m[i]);
    end
  endtask

  // One clock: predict the coming edge from current inputs, then check outputs.
  task automatic tick();
    for (int i = 0; i < NI; i++) begin
      if (req_v[i] && !rst && !in_rst && (k >= ready_from[i])) model_accept(i);
    end
    if (rst) begin
      in_rst = 1'b1;
      rd_q.delete();
      for (int i = 0; i < NI; i++) begin
        ready_from[i] = 1 << 30;
        oor_m[i] = 1'b0;
      end
    end else if (in_rst) begin
      in_rst = 1'b0;
      for (int i = 0; i < NI; i++) ready_from[i] = k + 1;
    end
    @(posedge clk);
    @(negedge clk);
    k++;
    check_outputs();
  endtask

  // ---------------- driver ----------------
  task automatic access(input int i, input bit r, input logic [17:0] a,
                        input logic [1:0] b, input logic [15:0] d, output int due);
    int waited;
    waited = 0;
    while (!(!in_rst && k >= ready_from[i]) && waited < 20) begin
      tick();
      waited++;
    end
    if (waited >= 20) begin
      errors++;
      checks++;
      $display("FAIL ready_wait inst=%0d cyc=%0d got=timeout want=ready", i, k);
    end
    rd = r; addr = a; be = b; wdata = d;
    req_v[i] = 1'b1;
    due = k + lat_of(i);
    tick();
    req_v[i] = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          inst;
    bit          rd;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(input int i, input bit r, input logic [17:0] a,
                              input logic [1:0] b, input logic [15:0] d, input logic [15:0] e);
    vec_t v;
    v.inst = i; v.rd = r; v.addr = a; v.be = b; v.wdata = d; v.exp = e;
    return v;
  endfunction

  initial begin
    int due;
    for (int i = 0; i < NI; i++) begin
      ready_from[i] = 1 << 30;
      oor_m[i] = 1'b0;
    end

    vecs.push_back(mk(0, 0, 18'd3, 2'b11, 16'hA55A, 16'h0));
    vecs.push_back(mk(0, 0, 18'd3, 2'b01, 16'h00FF, 16'h0));
    vecs.push_back(mk(0, 1, 18'd3, 2'b00, 16'h0,    16'hA5FF));
    vecs.push_back(mk(0, 0, 18'd3, 2'b10, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 1, 18'd3, 2'b11, 16'h0,    16'h12FF));
    vecs.push_back(mk(0, 0, 18'd7, 2'b11, 16'h1357, 16'h0));
    vecs.push_back(mk(0, 0, 18'd7, 2'b00, 16'hCAFE, 16'h0));
    vecs.push_back(mk(0, 1, 18'd7, 2'b00, 16'h0,    16'h1357));
    vecs.push_back(mk(1, 0, 18'd0, 2'b11, 16'h1111, 16'h0));
    vecs.push_back(mk(1, 0, 18'd1, 2'b11, 16'h2222, 16'h0));
    vecs.push_back(mk(1, 0, 18'd2, 2'b11, 16'h3333, 16'h0));
    vecs.push_back(mk(1, 1, 18'd1, 2'b00, 16'h0,    16'h2222));
    vecs.push_back(mk(2, 0, 18'd9, 2'b11, 16'h5A5A, 16'h0));
    vecs.push_back(mk(2, 1, 18'd9, 2'b00, 16'h0,    16'h5A5A));
`ifdef SRAM_RESP_OOR_CHECK_EN
    vecs.push_back(mk(0, 0, 18'd5,     2'b11, 16'h1234, 16'h0));
    vecs.push_back(mk(0, 0, 18'h00405, 2'b11, 16'hFFFF, 16'h0));
    vecs.push_back(mk(0, 1, 18'h00405, 2'b00, 16'h0,    16'hDEAD));
    vecs.push_back(mk(0, 1, 18'd5,     2'b00, 16'h0,    16'h1234));
`else
    vecs.push_back(mk(0, 0, 18'h00405, 2'b11, 16'hBEEF, 16'h0));
    vecs.push_back(mk(0, 1, 18'd5,     2'b00, 16'h0,    16'hBEEF));
    vecs.push_back(mk(0, 0, 18'h3FC08, 2'b11, 16'h0F0F, 16'h0));
    vecs.push_back(mk(0, 1, 18'd8,     2'b00, 16'h0,    16'h0F0F));
`endif

    // ---- reset held 5 cycles ----
    @(negedge clk);
    for (int n = 0; n < 5; n++) tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_data", i, rdat_v[i], 16'h0000);
      chk("rst_ready", i, rdy_v[i], 0);
    end
    rst = 1'b0;
    tick();
    chk("ready_after_release", 0, {29'd0, rdy_v}, 32'd7);

    // ---- pacing on the default instance ----
    access(0, 1'b0, 18'd20, 2'b11, 16'h0000, due);
    chk("busy_low", 0, rdy_v[0], 0);
    tick();
    chk("busy_over", 0, rdy_v[0], 1);

    // ---- table ----
    foreach (vecs[v]) begin
      access(vecs[v].inst, vecs[v].rd, vecs[v].addr, vecs[v].be, vecs[v].wdata, due);
      if (vecs[v].rd) begin
        while (k < due) tick();
        chk("tbl_vld", vecs[v].inst, vld_v[vecs[v].inst], 1);
        chk("tbl_data", vecs[v].inst, rdat_v[vecs[v].inst], vecs[v].exp);
      end
    end
`ifdef SRAM_RESP_OOR_CHECK_EN
    chk("oor_sticky", 0, oor_v[0], 1);
`else
    chk("oor_zero", 0, oor_v[0], 0);
`endif

    // ---- back-to-back reads, no busy time, latency 3 ----
    access(1, 1'b1, 18'd0, 2'b00, 16'h0, due);
    access(1, 1'b1, 18'd1, 2'b00, 16'h0, due);
    access(1, 1'b1, 18'd2, 2'b00, 16'h0, due);
    chk("b2b_vld0", 1, vld_v[1], 1);
    chk("b2b_data0", 1, rdat_v[1], 16'h1111);
    tick();
    chk("b2b_vld1", 1, vld_v[1], 1);
    chk("b2b_data1", 1, rdat_v[1], 16'h2222);
    tick();
    chk("b2b_vld2", 1, vld_v[1], 1);
    chk("b2b_data2", 1, rdat_v[1], 16'h3333);
    tick();
    chk("b2b_end", 1, vld_v[1], 0);

    // ---- reset two cycles after a read on latency 4 ----
    access(2, 1'b1, 18'd9, 2'b00, 16'h0, due);
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("rst_no_vld", 2, vld_v[2], 0);
    end
    access(2, 1'b1, 18'd9, 2'b00, 16'h0, due);
    for (int n = 0; n < 2; n++) begin
      tick();
      chk("post_rst_early", 2, vld_v[2], 0);
    end
    tick();
    chk("post_rst_vld", 2, vld_v[2], 1);
    chk("post_rst_data", 2, rdat_v[2], 16'h5A5A);

    // ---- randomized traffic against the model ----
    for (int a = 0; a < 16; a++) begin
      for (int i = 0; i < NI; i++) access(i, 1'b0, 18'(a), 2'b11, 16'($urandom), due);
    end
    for (int n = 0; n < 600; n++) begin
      logic [7:0] hi;
      hi = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      for (int i = 0; i < NI; i++) req_v[i] = 1'($urandom_range(0, 1));
      rd    = 1'($urandom_range(0, 1));
      addr  = {hi, 6'd0, 4'($urandom_range(0, 15))};
      be    = 2'($urandom_range(0, 3));
      wdata = 16'($urandom);
      tick();
    end
    req_v = '0;
    for (int n = 0; n < 8; n++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running want=finished", k);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_bram_responder.md
# sram_bram_responder

On-chip stand-in for the external SRAM controller: it is the responder on the `sram_req`/`sram_ready` request interface, serving reads and byte-masked writes from an internal block-RAM array. It lets the UART-to-SRAM queue path run and be tested on boards or benches without external SRAM. Access pacing and read latency are parameterized so the requester's flow control is exercised the same way the real controller exercises it.

## Interface
Parameters:
- `ADDR_W`, default 10: words in the array = 2^ADDR_W, legal range 4..14.
- `RD_LAT`, default 2: cycles from read acceptance to `sram_rd_data_vld`, legal range 1..4.
- `BUSY_CYC`, default 1: cycles `sram_ready` stays low after each accepted access, legal range 0..7.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `sram_req`  in  1  requester has an access pending.
- `sram_ready`  out  1  responder can accept an access this cycle.
- `sram_rd`  in  1  1 = read, 0 = write.
- `sram_addr`  in  18  word address.
- `sram_be`  in  2  byte enables for writes: bit0 = [7:0], bit1 = [15:8].
- `sram_wr_data`  in  16  write data.
- `sram_rd_data_vld`  out  1  one-cycle pulse per completed read.
- `sram_rd_data`  out  16  read data, valid only while `sram_rd_data_vld` is high.
- `oor_err`  out  1  sticky out-of-range flag. Tied 0 unless `SRAM_RESP_OOR_CHECK_EN` is defined.

## Operation
- **Acceptance.** An access is accepted on a rising edge where `sram_req && sram_ready`. `sram_rd`, `sram_addr`, `sram_be` and `sram_wr_data` are sampled on that edge only.
- **State machine.** RESET → IDLE → BUSY → IDLE.
  - RESET: `sram_ready`=0. Exits to IDLE on the first edge after `reset` deasserts.
  - IDLE: `sram_ready`=1.
    - On acceptance with BUSY_CYC>0: go to BUSY, load down-counter with BUSY_CYC-1.
    - With BUSY_CYC=0: stay in IDLE, so accesses can be accepted back-to-back every cycle.
  - BUSY: `sram_ready`=0. Decrement the counter each cycle; return to IDLE when it reads 0.
  - A request asserted in BUSY is ignored until IDLE.
- **Write.** The array word at `sram_addr[ADDR_W-1:0]` is updated on the acceptance edge, byte lanes gated by `sram_be`. `be`=2'b00 is a legal no-op that still consumes a handshake and busy time.
- **Read.** The full 16-bit word is returned; `sram_be` is ignored.
  - A valid bit plus data travel through an RD_LAT-deep pipeline.
  - Multiple reads in flight are legal (BUSY_CYC < RD_LAT) and return strictly in order.
- **Read-after-write.** A read accepted on any edge after a write's acceptance edge returns the written data.
- **Address width.** Without the macro, `sram_addr[17:ADDR_W]` is ignored, so addresses alias modulo 2^ADDR_W.
- **Array contents.** Not reset. Reads of never-written words return X in simulation. The bench must write before reading.

## Timing
- **Reset values.**
  - `sram_ready`=0, `sram_rd_data_vld`=0, `sram_rd_data`=16'h0000, `oor_err`=0.
  - Busy counter cleared; read pipeline valid bits cleared.
- **Read latency.** For a read accepted at edge T, `sram_rd_data_vld` is high for exactly the cycle after edge T+RD_LAT-1, i.e. registered RD_LAT edges after acceptance. RD_LAT=1 means vld in the cycle immediately after acceptance.
- **Pacing.** After acceptance at edge T, `sram_ready` is low for BUSY_CYC cycles and high again after edge T+BUSY_CYC.
- **Reset mid-operation.** All pending reads are discarded and never produce vld. Writes already accepted remain in the array. After release, `sram_ready` rises one edge after `reset` falls.
- **Simultaneous events.** A read completing in the same cycle as a new acceptance is legal; both proceed independently.

## Configuration
- **Macro:** `SRAM_RESP_OOR_CHECK_EN`.
- **Defined:** an access with `sram_addr >= 2^ADDR_W` is out of range.
  - Out-of-range writes are dropped.
  - Out-of-range reads return 16'hDEAD with normal latency and vld.
  - `oor_err` sets on the acceptance edge and stays set until `reset`.
  - Handshake and busy timing are unchanged.
- **Undefined:** no range check, addresses alias as above, `oor_err` constant 0.

## Test plan
- **Reset:** hold `reset` 5 cycles → all outputs at reset values; `sram_ready`=1 one edge after release; no vld.
- **Byte-lane write/read:** defaults. Write 16'hA55A to addr 3 with be=11, then 16'h00FF with be=01 → read of addr 3 returns 16'hA5FF; vld exactly 2 edges after read acceptance; `sram_ready` low 1 cycle after each access.
- **Back-to-back reads:** BUSY_CYC=0, RD_LAT=3. Write 16'h1111/2222/3333 to addrs 0/1/2, then hold `sram_req` with reads on 3 consecutive cycles → 3 consecutive vld pulses carrying 1111, 2222, 3333 in order.
- **Aliasing:** macro undefined, ADDR_W=10. Write 16'hBEEF to addr 18'h00405 → read of addr 5 returns 16'hBEEF; `oor_err`=0.
- **Out-of-range check:** macro defined. Write 16'h1234 to addr 5, then write 16'hFFFF to addr 18'h00405, then read addr 18'h00405 → read returns 16'hDEAD; `oor_err`=1 from the write's acceptance edge; a subsequent read of addr 5 returns 16'h1234.
- **Reset mid-read:** RD_LAT=4. Assert `reset` 2 cycles after a read is accepted → no vld pulse; first post-reset read returns correct data with full latency.
